matrix_row_scanner: RTL and testbench
=====================================

# matrix_row_scanner

Row-scan engine for the LED matrix: consumes the single-cycle strobe from the clock divider and time-multiplexes a double-buffered frame onto row-select and column-data lines. A blanking interval between rows suppresses ghosting. Host writes go to the back bank, and bank swaps take effect only at frame boundaries.

## Interface
- ROWS, 8, number of matrix rows (≥2)
- COLS, 8, number of columns / bits per row
- BLANK_TICKS, 1, ticks of all-off between rows (≥1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle strobe from divider, scan time base
- enable  in  1  scan enable; low forces IDLE
- wr_en  in  1  write strobe to back bank
- wr_row  in  clog2(ROWS)  row address for write
- wr_data  in  COLS  row pixel data, 1 = LED on
- swap_req  in  1  request front/back swap at next frame wrap
- row_sel  out  ROWS  one-hot active-high row drive
- col_data  out  COLS  column drive for selected row
- frame_start  out  1  one-cycle pulse on entering DISPLAY of row 0
- swap_done  out  1  one-cycle pulse on the cycle a swap is applied

## Operation
- Reset values: state IDLE, row_idx 0, blank_cnt 0, front-bank select 0, swap_pending 0, both banks all-zero, row_sel 0, col_data 0, frame_start 0, swap_done 0.
- States: IDLE, BLANK, DISPLAY.
- IDLE: outputs zero. If enable=1, go to BLANK with row_idx 0 and blank_cnt 0 on the next edge.
- BLANK: row_sel=0, col_data=0. On tick:
  - if blank_cnt==BLANK_TICKS-1, go to DISPLAY and clear blank_cnt;
  - otherwise increment blank_cnt.
- DISPLAY: row_sel=1<<row_idx, col_data=front[row_idx]. On tick, go to BLANK.
  - row_idx increments, wrapping ROWS-1 → 0.
  - On the wrap, if swap_pending or swap_req is high that cycle: toggle front select, clear swap_pending, pulse swap_done.
- swap_req outside a wrap cycle sets swap_pending. Repeated requests while pending have no further effect.
- Writes: when wr_en=1, back[wr_row] ← wr_data, where back is the bank that is back at the start of that cycle. A write in the swap cycle lands in the bank that becomes front.
- wr_row ≥ ROWS: write ignored.
- enable=0 in any state: next edge goes to IDLE, outputs 0, row_idx 0, blank_cnt 0. swap_pending and bank contents are retained.
- tick is ignored in IDLE.

## Timing
- All outputs are registered. A state change caused by tick at edge N is visible at row_sel/col_data after edge N (zero added latency).
- Row period = (1+BLANK_TICKS) ticks. Frame period = ROWS·(1+BLANK_TICKS) ticks.
- From enable rising, the first DISPLAY (row 0) starts BLANK_TICKS ticks after entering BLANK.
- frame_start is asserted in the same cycle row_sel first becomes 0…01.
- col_data is sampled from the front bank at the transition into DISPLAY and held constant for the whole DISPLAY period. Writes never alter the displayed row mid-period, because writes target only the back bank.
- Asynchronous rst mid-scan: outputs go to 0 immediately. Scanning resumes from IDLE after release.
- tick and the enable falling edge in the same cycle: enable wins, go to IDLE.

## Structure
- Package matrix_pkg: scan-state enum (IDLE/BLANK/DISPLAY), ROW_W=clog2(ROWS), BLANK_W=clog2(BLANK_TICKS+1).
- Sub-module matrix_frame_buffer:
  - two banks of ROWS×COLS registers;
  - synchronous write port to the back bank;
  - combinational read port from the front bank;
  - bank-select input.
- Top level holds the FSM, counters, swap logic and output registers.

## Test plan
- Reset then enable=1 with tick every 4 clk, ROWS=8, BLANK_TICKS=1: row_sel sequence 0, 01, 0, 02, 0, 04 … 80, 0, 01. frame_start pulses once per 16 ticks.
- Write back rows 0..7 = 0x11·(r+1), swap_req once mid-frame: swap_done pulses exactly at the next row-7→row-0 wrap. Following frame shows col_data 0x11, 0x22 … 0x88. Preceding rows still show the old front bank.
- swap_req asserted exactly in the wrap cycle: swap is applied at that wrap with no frame delay. A second request while pending produces one swap only.
- Write to row 3 of the back bank while row 3 is displayed: col_data is unchanged until after the swap.
- Deassert enable while in DISPLAY of row 5: next cycle row_sel=0 and state is IDLE. Re-enable: scan restarts at row 0 after a BLANK period.
- Assert rst asynchronously between clk edges during DISPLAY: row_sel/col_data read 0 before the next edge. Banks read 0 after release.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared scan-state type and default geometry for the LED matrix scanner
package matrix_pkg;

  localparam int DEF_ROWS        = 8;
  localparam int DEF_COLS        = 8;
  localparam int DEF_BLANK_TICKS = 1;
  localparam int ROW_W           = $clog2(DEF_ROWS);
  localparam int BLANK_W         = $clog2(DEF_BLANK_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_DISPLAY = 2'd2
  } scan_state_e;

endpackage

// File: rtl/matrix_frame_buffer.sv
// rtl/matrix_frame_buffer.sv - double-buffered frame store, writes to back bank, reads from front
module matrix_frame_buffer #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            front_sel,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_data
);

  logic [COLS-1:0] bank_q [2][ROWS];

  // The back bank is whichever one is not front at the start of the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank_q[b][r] <= '0;
        end
      end
    end else if (wr_en && (32'(wr_row) < ROWS)) begin
      bank_q[!front_sel][wr_row] <= wr_data;
    end
  end

  assign rd_data = bank_q[front_sel][rd_row];

endmodule

// File: rtl/matrix_row_scanner.sv
// rtl/matrix_row_scanner.sv - row-scan FSM with blanking and frame-aligned bank swaps
module matrix_row_scanner
  import matrix_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int BLANK_TICKS = DEF_BLANK_TICKS,
  localparam int RW         = $clog2(ROWS),
  localparam int BW         = $clog2(BLANK_TICKS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic            frame_start,
  output logic            swap_done
);

  localparam logic [ROWS-1:0] ROW0_SEL = ROWS'(1);

  scan_state_e     state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic            front_q, front_d;
  logic            pend_q, pend_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [COLS-1:0] col_q, col_d;
  logic            fstart_q, fstart_d;
  logic            sdone_q, sdone_d;
  logic [COLS-1:0] front_row;

  matrix_frame_buffer #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_fb (
    .clk      (clk),
    .rst      (rst),
    .front_sel(front_q),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .rd_row   (row_q),
    .rd_data  (front_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      blank_q   <= '0;
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
      row_sel_q <= '0;
      col_q     <= '0;
      fstart_q  <= 1'b0;
      sdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      blank_q   <= blank_d;
      front_q   <= front_d;
      pend_q    <= pend_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      fstart_q  <= fstart_d;
      sdone_q   <= sdone_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    blank_d   = blank_q;
    front_d   = front_q;
    pend_d    = pend_q | swap_req;
    row_sel_d = '0;
    col_d     = '0;
    fstart_d  = 1'b0;
    sdone_d   = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      row_d   = '0;
      blank_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          row_d   = '0;
          blank_d = '0;
        end
        ST_BLANK: begin
          if (tick) begin
            if (blank_q == BW'(BLANK_TICKS - 1)) begin
              state_d   = ST_DISPLAY;
              blank_d   = '0;
              row_sel_d = ROW0_SEL << row_q;
              col_d     = front_row;
              fstart_d  = (row_q == '0);
            end else begin
              blank_d = blank_q + BW'(1);
            end
          end
        end
        ST_DISPLAY: begin
          if (tick) begin
            state_d = ST_BLANK;
            if (row_q == RW'(ROWS - 1)) begin
              row_d = '0;
              // A request arriving on the wrap itself is honoured without waiting a frame.
              if (pend_q || swap_req) begin
                front_d = !front_q;
                pend_d  = 1'b0;
                sdone_d = 1'b1;
              end
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            row_sel_d = row_sel_q;
            col_d     = col_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_q;
  assign frame_start = fstart_q;
  assign swap_done   = sdone_q;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// tb/tb_matrix_row_scanner.sv - randomized self-checking bench against a tick-count reference model
module tb_matrix_row_scanner;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int BT   = 1;
  localparam int RP   = 1 + BT;
  localparam int FP   = ROWS * RP;

  logic            clk = 1'b0;
  logic            rst;
  logic            tick, enable, wr_en, swap_req;
  logic [2:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_start, swap_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: scan position is just the number of ticks seen since scanning began.
  bit              m_active;
  int              m_k;
  bit              m_front, m_pend;
  logic [COLS-1:0] m_bank [2][ROWS];
  logic [ROWS-1:0] m_rowsel;
  logic [COLS-1:0] m_col;
  bit              m_fs, m_sd;

  matrix_row_scanner #(.ROWS(ROWS), .COLS(COLS), .BLANK_TICKS(BT)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_start(frame_start),
    .swap_done  (swap_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_k = 0; m_front = 0; m_pend = 0;
    m_rowsel = '0; m_col = '0; m_fs = 0; m_sd = 0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++) m_bank[b][r] = '0;
  endtask

  task automatic model_edge();
    bit old_front;
    int row;
    old_front = m_front;
    m_fs = 0;
    m_sd = 0;
    if (!enable) begin
      m_active = 0; m_k = 0; m_rowsel = '0; m_col = '0;
      m_pend = m_pend | swap_req;
    end else if (!m_active) begin
      m_active = 1; m_k = 0; m_rowsel = '0; m_col = '0;
      m_pend = m_pend | swap_req;
    end else if (tick) begin
      if ((m_k % FP) == FP - 1 && (m_pend || swap_req)) begin
        m_front = !m_front; m_pend = 0; m_sd = 1;
      end else begin
        m_pend = m_pend | swap_req;
      end
      m_k++;
      if ((m_k % RP) == BT) begin
        row = (m_k / RP) % ROWS;
        m_rowsel = ROWS'(1) << row;
        m_col = m_bank[old_front][row];
        m_fs = (row == 0);
      end else begin
        m_rowsel = '0; m_col = '0;
      end
    end else begin
      m_pend = m_pend | swap_req;
    end
    if (wr_en && int'(wr_row) < ROWS) m_bank[!old_front][wr_row] = wr_data;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("row_sel", 32'(row_sel), 32'(m_rowsel));
    check_eq("col_data", 32'(col_data), 32'(m_col));
    check_eq("frame_start", 32'(frame_start), 32'(m_fs));
    check_eq("swap_done", 32'(swap_done), 32'(m_sd));
  endtask

  initial begin
    int waited;
    rst = 1'b1; tick = 0; enable = 0; wr_en = 0; swap_req = 0; wr_row = '0; wr_data = '0;
    model_reset();
    #12;
    check_eq("rst_row_sel", 32'(row_sel), 32'h0);
    check_eq("rst_col_data", 32'(col_data), 32'h0);
    check_eq("rst_frame_start", 32'(frame_start), 32'h0);
    check_eq("rst_swap_done", 32'(swap_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fixed cadence: tick every 4 clocks, load back bank, one swap request mid-frame.
    enable = 1;
    for (int c = 0; c < 240; c++) begin
      tick     = (c % 4 == 3);
      wr_en    = (c < ROWS);
      wr_row   = 3'(c);
      wr_data  = COLS'(8'h11 * (c + 1));
      swap_req = (c == 40);
      step();
    end

    // Random traffic: irregular ticks, enable drops, writes and swap requests.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      tick     = ($urandom_range(0, 2) == 0);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_row   = 3'($urandom_range(0, ROWS - 1));
      wr_data  = COLS'($urandom);
      swap_req = ($urandom_range(0, 19) == 0);
      step();
    end

    // Asynchronous reset while a row is lit.
    enable = 1; tick = 1; wr_en = 0; swap_req = 0;
    waited = 0;
    step();
    while (row_sel == '0 && waited < 100) begin
      step();
      waited++;
    end
    check_eq("reach_display", 32'(row_sel != '0), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_row_sel", 32'(row_sel), 32'h0);
    check_eq("async_rst_col_data", 32'(col_data), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Both banks must read back as zero after the reset.
    for (int c = 0; c < 2 * FP + 8; c++) begin
      tick     = 1;
      swap_req = (c == 5);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
